dsp_mac_sequencer: RTL and testbench

Sequences one DSP48A1 slice as a signed multiply-accumulate engine computing a dot product of length `len`. Operand pairs stream in over a valid/ready handshake. The block drives the slice's A/B operands, OPMODE and CE, and returns the accumulated P value as a one-cycle result strobe. It sits between the coefficient/sample buffers and the DSP48A1 instance, which is configured with A1REG=B1REG=1, MREG=1, PREG=1 and all other registers bypassed.

---
 rtl/dsp_mac_sequencer_if.sv | 30 +++
 rtl/dsp_mac_sequencer.sv | 116 +++++++++++
 tb/tb_dsp_mac_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_sequencer_if.sv
// Operand stream, DSP48A1 control and result strobe between the sequencer (master) and its environment (slave).
// Operands and start use valid/ready; results are a one-cycle strobe with no backpressure.
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [17:0]      in_a;
    logic [17:0]      in_b;
    logic [17:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic [7:0]       dsp_opmode;
    logic             dsp_ce;
    logic [47:0]      dsp_p;
    logic             res_valid;
    logic [47:0]      res_data;

    modport master (
        input  start, len, in_valid, in_a, in_b, dsp_p,
        output busy, in_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, res_valid, res_data
    );

    modport slave (
        output start, len, in_valid, in_a, in_b, dsp_p,
        input  busy, in_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, res_valid, res_data
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Drives a DSP48A1 as a signed MAC over len operand pairs; result strobes MUL_LAT+3 cycles after the last tap.
// in_ready is held low outside RUN; stalls insert OPMODE-hold bubbles and never drop CE.
module dsp_mac_sequencer #(
    parameter int LEN_W   = 8,
    parameter int MUL_LAT = 2
) (
    input  logic                CLK,
    input  logic                RST,
    dsp_mac_sequencer_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

    localparam logic [7:0] OP_LOAD = 8'h01;
    localparam logic [7:0] OP_ACC  = 8'h09;
    localparam logic [7:0] OP_HOLD = 8'h08;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    tag_t             tag_q [MUL_LAT+1];
    logic             p_last;

    logic             hs;
    logic             start_ok;
    tag_t             tag_in;

    always_comb begin
        hs           = bus.in_valid & bus.in_ready;
        start_ok     = bus.start && (bus.len != '0);
        tag_in       = '0;
        tag_in.vld   = hs;
        tag_in.first = hs && (cnt == '0);
        tag_in.last  = hs && (cnt == len_q - LEN_W'(1));
    end

    function automatic logic [7:0] opmode_for(input tag_t t);
        if (t.first)
            return OP_LOAD;
        else if (t.vld)
            return OP_ACC;
        else
            return OP_HOLD;
    endfunction

    // tag_q[MUL_LAT] sits at the post-adder; OPMODE is registered from the stage before it so both line up.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            len_q          <= '0;
            cnt            <= '0;
            for (int i = 0; i <= MUL_LAT; i++)
                tag_q[i] <= '0;
            p_last         <= 1'b0;
            bus.busy       <= 1'b0;
            bus.in_ready   <= 1'b0;
            bus.dsp_a      <= '0;
            bus.dsp_b      <= '0;
            bus.dsp_opmode <= 8'h00;
            bus.dsp_ce     <= 1'b0;
            bus.res_valid  <= 1'b0;
            bus.res_data   <= '0;
        end else begin
            bus.dsp_ce     <= 1'b1;
            bus.res_valid  <= 1'b0;
            tag_q[0]       <= tag_in;
            for (int i = 1; i <= MUL_LAT; i++)
                tag_q[i] <= tag_q[i-1];
            p_last         <= tag_q[MUL_LAT].vld & tag_q[MUL_LAT].last;
            bus.dsp_opmode <= opmode_for(tag_q[MUL_LAT-1]);

            if (hs) begin
                bus.dsp_a <= bus.in_a;
                bus.dsp_b <= bus.in_b;
                cnt       <= cnt + LEN_W'(1);
            end

            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        len_q        <= bus.len;
                        cnt          <= '0;
                        bus.busy     <= 1'b1;
                        bus.in_ready <= 1'b1;
                        state        <= RUN;
                    end else begin
                        state        <= IDLE;
                    end
                end
                RUN: begin
                    if (tag_in.last) begin
                        bus.in_ready <= 1'b0;
                        state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last product is in P this cycle.
                    if (p_last) begin
                        bus.res_data  <= bus.dsp_p;
                        bus.res_valid <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice (A1/B1, M, P registers; clears when CE is low).
module tb_dsp_mac_sequencer;

    localparam int LEN_W = 8;
    localparam int N     = 24;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    dsp_mac_sequencer_if #(.LEN_W(LEN_W)) bus ();

    dsp_mac_sequencer #(.LEN_W(LEN_W), .MUL_LAT(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Behavioural DSP48A1 slice
    logic signed [17:0] m_a1, m_b1;
    logic signed [35:0] m_m;
    logic        [47:0] m_p;
    logic        [47:0] m_x, m_z;

    always_comb begin
        m_x = (bus.dsp_opmode[1:0] == 2'b01) ? {{12{m_m[35]}}, m_m} : 48'd0;
        m_z = (bus.dsp_opmode[3:2] == 2'b10) ? m_p : 48'd0;
    end

    always @(posedge CLK) begin
        if (bus.dsp_ce !== 1'b1) begin
            m_a1 <= '0;
            m_b1 <= '0;
            m_m  <= '0;
            m_p  <= '0;
        end else begin
            m_a1 <= bus.dsp_a;
            m_b1 <= bus.dsp_b;
            m_m  <= m_a1 * m_b1;
            m_p  <= m_x + m_z;
        end
    end

    assign bus.dsp_p = m_p;

    int checks;
    int errors;

    logic             s_rst   [N];
    logic             s_start [N];
    logic [LEN_W-1:0] s_len   [N];
    logic             s_vld   [N];
    logic [17:0]      s_a     [N];
    logic [17:0]      s_b     [N];

    logic [7:0]  l_op   [N];
    logic        l_rv   [N];
    logic        l_ir   [N];
    logic        l_busy [N];
    logic        l_ce   [N];
    logic [17:0] l_a    [N];
    logic [17:0] l_b    [N];
    logic [47:0] l_rd   [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_stim();
        for (int t = 0; t < N; t++) begin
            s_rst[t]   = 1'b0;
            s_start[t] = 1'b0;
            s_len[t]   = '0;
            s_vld[t]   = 1'b0;
            s_a[t]     = '0;
            s_b[t]     = '0;
        end
    endtask

    task automatic strt(input int t, input int n);
        s_start[t] = 1'b1;
        s_len[t]   = LEN_W'(n);
    endtask

    task automatic pair(input int t, input logic signed [17:0] a, input logic signed [17:0] b);
        s_vld[t] = 1'b1;
        s_a[t]   = a;
        s_b[t]   = b;
    endtask

    // Cycle t of a run starts 1 time unit after a rising edge; registered outputs are stable there.
    task automatic run(input int n);
        for (int t = 0; t < n; t++) begin
            RST          = s_rst[t];
            bus.start    = s_start[t];
            bus.len      = s_len[t];
            bus.in_valid = s_vld[t];
            bus.in_a     = s_a[t];
            bus.in_b     = s_b[t];
            l_op[t]      = bus.dsp_opmode;
            l_rv[t]      = bus.res_valid;
            l_ir[t]      = bus.in_ready;
            l_busy[t]    = bus.busy;
            l_ce[t]      = bus.dsp_ce;
            l_a[t]       = bus.dsp_a;
            l_b[t]       = bus.dsp_b;
            l_rd[t]      = bus.res_data;
            tick();
        end
        RST          = 1'b0;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        clear_stim();
    endtask

    function automatic int strobes(input int n);
        int c = 0;
        for (int t = 0; t < n; t++)
            if (l_rv[t] === 1'b1)
                c++;
        return c;
    endfunction

    initial begin
        checks       = 0;
        errors       = 0;
        clear_stim();
        RST          = 1'b1;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        repeat (2) tick();

        chk("rst_busy",     bus.busy,       0);
        chk("rst_in_ready", bus.in_ready,   0);
        chk("rst_res_vld",  bus.res_valid,  0);
        chk("rst_dsp_a",    bus.dsp_a,      0);
        chk("rst_dsp_b",    bus.dsp_b,      0);
        chk("rst_res_data", bus.res_data,   0);
        chk("rst_ce",       bus.dsp_ce,     0);
        chk("rst_opmode",   bus.dsp_opmode, 8'h00);

        RST = 1'b0;
        tick();
        chk("post_rst_ce",     bus.dsp_ce,     1);
        chk("post_rst_opmode", bus.dsp_opmode, 8'h08);

        // Single tap: handshake at t1, strobe at t6
        strt(0, 1);
        pair(1, 3, -4);
        run(10);
        chk("single_ready_t1",  l_ir[1],   1);
        chk("single_busy_t1",   l_busy[1], 1);
        chk("single_dsp_a",     l_a[2],    3);
        chk("single_dsp_b",     l_b[2],    64'h3FFFC);
        chk("single_ready_off", l_ir[2],   0);
        chk("single_op_load",   l_op[4],   8'h01);
        chk("single_no_early",  l_rv[5],   0);
        chk("single_strobe",    l_rv[6],   1);
        chk("single_result",    l_rd[6],   48'hFFFF_FFFF_FFF4);
        chk("single_busy_done", l_busy[6], 0);
        chk("single_nstrobe",   strobes(10), 1);

        // Four taps back-to-back, with a start during RUN that must be ignored
        strt(0, 4);
        pair(1, 1, 2);
        pair(2, 3, 4);
        strt(2, 2);
        pair(3, 5, 6);
        pair(4, 7, 8);
        run(14);
        chk("four_ready_t4", l_ir[4],   1);
        chk("four_ready_t5", l_ir[5],   0);
        chk("four_busy_t3",  l_busy[3], 1);
        chk("four_op_t4",    l_op[4],   8'h01);
        chk("four_op_t5",    l_op[5],   8'h09);
        chk("four_op_t6",    l_op[6],   8'h09);
        chk("four_op_t7",    l_op[7],   8'h09);
        chk("four_op_t8",    l_op[8],   8'h08);
        chk("four_rd_held",  l_rd[8],   48'hFFFF_FFFF_FFF4);
        chk("four_strobe",   l_rv[9],   1);
        chk("four_result",   l_rd[9],   100);
        chk("four_nstrobe",  strobes(14), 1);

        // Two bubbles between taps 1 and 2
        strt(0, 3);
        pair(1, 10, 10);
        pair(4, -20, 1);
        pair(5, 131071, 2);
        run(14);
        chk("bub_dsp_a_hold", l_a[3],  10);
        chk("bub_op_t4",      l_op[4], 8'h01);
        chk("bub_op_t5",      l_op[5], 8'h08);
        chk("bub_op_t6",      l_op[6], 8'h08);
        chk("bub_op_t7",      l_op[7], 8'h09);
        chk("bub_op_t8",      l_op[8], 8'h09);
        chk("bub_no_early",   l_rv[9], 0);
        chk("bub_strobe",     l_rv[10], 1);
        chk("bub_result",     l_rd[10], 262222);

        // Start with len=0 is ignored
        strt(0, 0);
        run(4);
        chk("len0_busy",    l_busy[1], 0);
        chk("len0_ready",   l_ir[1],   0);
        chk("len0_nstrobe", strobes(4), 0);

        // Extremes, then a job started in the DONE cycle
        strt(0, 2);
        pair(1, -131072, -131072);
        pair(2, -131072, -131072);
        strt(7, 1);
        pair(8, 5, -7);
        run(16);
        chk("ext_strobe",   l_rv[7],   1);
        chk("ext_result",   l_rd[7],   48'h8_0000_0000);
        chk("ext_busy_dn",  l_busy[7], 0);
        chk("b2b_ready",    l_ir[8],   1);
        chk("b2b_busy",     l_busy[8], 1);
        chk("b2b_strobe",   l_rv[13],  1);
        chk("b2b_result",   l_rd[13],  48'hFFFF_FFFF_FFDD);
        chk("b2b_nstrobe",  strobes(16), 2);

        // Reset during DRAIN of a len=4 job, then a fresh len=1 job
        strt(0, 4);
        pair(1, 1, 1);
        pair(2, 1, 1);
        pair(3, 1, 1);
        pair(4, 1, 1);
        s_rst[6] = 1'b1;
        s_rst[7] = 1'b1;
        strt(10, 1);
        pair(11, 2, 2);
        run(20);
        chk("mid_rst_busy",   l_busy[7], 0);
        chk("mid_rst_ready",  l_ir[7],   0);
        chk("mid_rst_dsp_a",  l_a[7],    0);
        chk("mid_rst_rd",     l_rd[7],   0);
        chk("mid_rst_ce",     l_ce[7],   0);
        chk("mid_rst_op",     l_op[7],   8'h00);
        chk("mid_rst_ce_on",  l_ce[9],   1);
        chk("mid_rst_no_res", l_rv[9],   0);
        chk("after_rst_strb", l_rv[16],  1);
        chk("after_rst_res",  l_rd[16],  4);
        chk("mid_rst_nstrb",  strobes(20), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
